// File: rtl/fsm_burst_pkg.sv
// Shared types and default parameters for the burst-read sequencer.
package fsm_burst_pkg;

  // Sequencer state encoding (3-bit, values fixed so that waveforms stay readable).
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_DLY  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam int BURST_W_DEF   = 4;
  localparam int RETRY_W_DEF   = 3;
  localparam int MAX_RETRY_DEF = 3;

endpackage : fsm_burst_pkg

// File: rtl/fsm_burst_rd_if.sv
// Command/target handshake bundle of the burst-read sequencer.
// master = command issuer + target side, slave = the sequencer itself.
interface fsm_burst_rd_if
  import fsm_burst_pkg::*;
#(
  parameter int BURST_W = BURST_W_DEF
);

  logic               go;
  logic [BURST_W-1:0] burst_len;
  logic               ws;
  logic               abort;
  logic               rd;
  logic               ds;
  logic               err;
  logic               busy;
  logic [BURST_W-1:0] beat_cnt;
  logic               beat_ok;

  modport master (
    output go, burst_len, ws, abort,
    input  rd, ds, err, busy, beat_cnt, beat_ok
  );

  modport slave (
    input  go, burst_len, ws, abort,
    output rd, ds, err, busy, beat_cnt, beat_ok
  );

endinterface : fsm_burst_rd_if

// File: rtl/fsm_burst_rd.sv
// Burst-read sequencer: issues burst_len+1 read beats per accepted go,
// retrying a beat on wait-state up to MAX_RETRY times, with abort support.
// rd/ds/err/busy are a Moore decode of the state register; beat_ok is
// the only output that looks at the live ws/abort inputs.
module fsm_burst_rd
  import fsm_burst_pkg::*;
#(
  parameter int BURST_W   = BURST_W_DEF,
  parameter int RETRY_W   = RETRY_W_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  fsm_burst_rd_if.slave  bus
);

  // The retry counter must be able to hold MAX_RETRY without wrapping.
  if (MAX_RETRY > ((32'sd1 << RETRY_W) - 32'sd1)) begin : g_bad_max_retry
    $error("fsm_burst_rd: MAX_RETRY does not fit in RETRY_W bits");
  end

  localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRY);

  state_e             state_q, state_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;

  // State and counter registers; reset discards any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= {BURST_W{1'b0}};
      beat_cnt_q  <= {BURST_W{1'b0}};
      retry_cnt_q <= {RETRY_W{1'b0}};
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  // Next-state and counter update; abort always outranks ws in READ/DLY.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    retry_cnt_d = retry_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          len_d       = bus.burst_len;
          beat_cnt_d  = {BURST_W{1'b0}};
          retry_cnt_d = {RETRY_W{1'b0}};
          state_d     = ST_READ;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_READ: begin
        if (bus.abort) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_DLY;
        end
      end
      ST_DLY: begin
        if (bus.abort) begin
          state_d = ST_ERR;
        end else if (bus.ws) begin
          if (retry_cnt_q == MAX_RETRY_V) begin
            state_d = ST_ERR;
          end else begin
            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
            state_d     = ST_READ;
          end
        end else if (beat_cnt_q == len_q) begin
          state_d = ST_DONE;
        end else begin
          beat_cnt_d  = beat_cnt_q + BURST_W'(1);
          retry_cnt_d = {RETRY_W{1'b0}};
          state_d     = ST_READ;
        end
      end
      // Counters are cleared on the way out so beat_cnt reads 0 in IDLE.
      ST_DONE, ST_ERR: begin
        beat_cnt_d  = {BURST_W{1'b0}};
        retry_cnt_d = {RETRY_W{1'b0}};
        state_d     = ST_IDLE;
      end
      default: begin
        beat_cnt_d  = {BURST_W{1'b0}};
        retry_cnt_d = {RETRY_W{1'b0}};
        state_d     = ST_IDLE;
      end
    endcase
  end

  assign bus.rd       = (state_q == ST_READ) || (state_q == ST_DLY);
  assign bus.ds       = (state_q == ST_DONE);
  assign bus.err      = (state_q == ST_ERR);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.beat_cnt = beat_cnt_q;
  assign bus.beat_ok  = (state_q == ST_DLY) && !bus.ws && !bus.abort;

endmodule : fsm_burst_rd
